// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller for the ID stage.
// Resolves operand sources across N_FWD producer stages, raises load-use
// stalls, freezes the pipe while memory is busy, and keeps perf counters.
module hazard_fwd_unit #(
   parameter int RA_W         = 5,
   parameter int N_FWD        = 2,
   parameter int LOAD_USE_GAP = 1,
   parameter int DELAY_SLOT   = 1,
   parameter int TIMEOUT      = 255,
   parameter int CNT_W        = 32,
   localparam int SEL_W       = $clog2(N_FWD + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [RA_W-1:0]       id_rs,
   input  logic [RA_W-1:0]       id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_is_store,
   input  logic                  id_branch_taken,
   input  logic [N_FWD-1:0]      prod_wen,
   input  logic [N_FWD*RA_W-1:0] prod_waddr,
   input  logic [N_FWD-1:0]      prod_is_load,
   input  logic                  mem_req,
   input  logic                  mio_ready,
   output logic [SEL_W-1:0]      fwd_rs_sel,
   output logic [SEL_W-1:0]      fwd_rt_sel,
   output logic                  fwd_rt_late,
   output logic                  stall_front,
   output logic                  bubble_ex,
   output logic                  freeze_all,
   output logic                  branch_go,
   output logic                  flush_ifid,
   output logic [1:0]            hz_state,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      mem_wait_cycles
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [1:0]       state_q, state_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] mem_wait_cycles_q, mem_wait_cycles_d;

   logic             rs_found, rt_found;
   logic             rs_hazard, rt_hazard, rt_exempt;
   logic [SEL_W-1:0] rs_sel, rt_sel;
   logic             lu_hazard;

   // Youngest matching producer wins; too-young loads become hazards instead of forwards
   always_comb begin
      rs_found  = 1'b0;
      rt_found  = 1'b0;
      rs_hazard = 1'b0;
      rt_hazard = 1'b0;
      rt_exempt = 1'b0;
      rs_sel    = '0;
      rt_sel    = '0;
      for (int k = 0; k < N_FWD; k++) begin
         if (!rs_found && id_valid && id_uses_rs && prod_wen[k] &&
             (prod_waddr[k*RA_W +: RA_W] != '0) &&
             (prod_waddr[k*RA_W +: RA_W] == id_rs)) begin
            rs_found = 1'b1;
            if (prod_is_load[k] && (k < LOAD_USE_GAP)) begin
               rs_hazard = 1'b1;
            end else begin
               rs_sel = SEL_W'(k + 1);
            end
         end
         if (!rt_found && id_valid && id_uses_rt && prod_wen[k] &&
             (prod_waddr[k*RA_W +: RA_W] != '0) &&
             (prod_waddr[k*RA_W +: RA_W] == id_rt)) begin
            rt_found = 1'b1;
            if (prod_is_load[k] && (k < LOAD_USE_GAP)) begin
               rt_hazard = 1'b1;
               if (id_is_store && (k == LOAD_USE_GAP - 1)) begin
                  rt_exempt = 1'b1;
               end
            end else begin
               rt_sel = SEL_W'(k + 1);
            end
         end
      end
   end

   // Pipeline control outputs derived from hazards and the memory handshake
   always_comb begin
      lu_hazard   = rs_hazard | (rt_hazard & ~rt_exempt);
      freeze_all  = mem_req & ~mio_ready;
      stall_front = lu_hazard & ~freeze_all;
      bubble_ex   = stall_front;
      branch_go   = id_branch_taken & id_valid & ~stall_front & ~freeze_all;
      flush_ifid  = (DELAY_SLOT == 0) ? branch_go : 1'b0;
      fwd_rs_sel  = rs_sel;
      fwd_rt_sel  = rt_sel;
      fwd_rt_late = rt_exempt;
   end

   // Next-state logic; a pending memory access overrides everything else
   always_comb begin
      state_d = state_q;
      if (freeze_all) begin
         state_d = ST_MEM_WAIT;
      end else begin
         case (state_q)
            ST_RUN:      state_d = lu_hazard ? ST_LU_STALL : ST_RUN;
            ST_LU_STALL: state_d = lu_hazard ? ST_LU_STALL : ST_RUN;
            ST_MEM_WAIT: state_d = mio_ready ? ST_RUN : ST_MEM_WAIT;
            default:     state_d = ST_RUN;
         endcase
      end
   end

   // Wait-length counter and sticky timeout flag; the flag never feeds back into control
   always_comb begin
      tmo_cnt_d     = '0;
      mem_timeout_d = mem_timeout_q;
      if (state_d == ST_MEM_WAIT) begin
         tmo_cnt_d = (tmo_cnt_q == TMO_W'(TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
         if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
            mem_timeout_d = 1'b1;
         end
      end
   end

   // Saturating performance counters for stall and freeze cycles
   always_comb begin
      stall_cycles_d    = stall_cycles_q;
      mem_wait_cycles_d = mem_wait_cycles_q;
      if (stall_front && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (freeze_all && (mem_wait_cycles_q != '1)) begin
         mem_wait_cycles_d = mem_wait_cycles_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= ST_RUN;
         tmo_cnt_q         <= '0;
         mem_timeout_q     <= 1'b0;
         stall_cycles_q    <= '0;
         mem_wait_cycles_q <= '0;
      end else begin
         state_q           <= state_d;
         tmo_cnt_q         <= tmo_cnt_d;
         mem_timeout_q     <= mem_timeout_d;
         stall_cycles_q    <= stall_cycles_d;
         mem_wait_cycles_q <= mem_wait_cycles_d;
      end
   end

   assign hz_state        = state_q;
   assign mem_timeout     = mem_timeout_q;
   assign stall_cycles    = stall_cycles_q;
   assign mem_wait_cycles = mem_wait_cycles_q;

endmodule
